// File: rtl/seq_state_pkg.sv
// Shared code/digit constants and transition helpers for the display-sequence state bus.
package seq_state_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned SEG_W  = 7;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [DIG_W-1:0]  digit_t;
    typedef logic [SEG_W-1:0]  seg_t;

    localparam code_t CODE_A = 3'b101;
    localparam code_t CODE_B = 3'b100;
    localparam code_t CODE_C = 3'b011;
    localparam code_t CODE_D = 3'b110;
    localparam code_t CODE_E = 3'b111;
    localparam code_t CODE_F = 3'b010;

    localparam digit_t DIG_2     = 4'h2;
    localparam digit_t DIG_3     = 4'h3;
    localparam digit_t DIG_5     = 4'h5;
    localparam digit_t DIG_6     = 4'h6;
    localparam digit_t DIG_BLANK = 4'hF;

    // Expected next code on the A..F ring; illegal codes map to themselves.
    function automatic code_t succ(input code_t code, input logic down);
        code_t nxt;
        nxt = code;
        unique case (code)
            CODE_A:  nxt = down ? CODE_F : CODE_B;
            CODE_B:  nxt = down ? CODE_A : CODE_C;
            CODE_C:  nxt = down ? CODE_B : CODE_D;
            CODE_D:  nxt = down ? CODE_C : CODE_E;
            CODE_E:  nxt = down ? CODE_D : CODE_F;
            CODE_F:  nxt = down ? CODE_E : CODE_A;
            default: nxt = code;
        endcase
        return nxt;
    endfunction

    function automatic logic code_legal(input code_t code);
        return (code != 3'b000) && (code != 3'b001);
    endfunction

    function automatic digit_t code_digit(input code_t code);
        digit_t d;
        d = DIG_BLANK;
        unique case (code)
            CODE_A, CODE_B, CODE_C: d = DIG_3;
            CODE_D:                 d = DIG_5;
            CODE_E:                 d = DIG_6;
            CODE_F:                 d = DIG_2;
            default:                d = DIG_BLANK;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seq_state_monitor_if.sv
// Bus between the state register (master) and the sequence monitor (slave).
interface seq_state_monitor_if #(
    parameter int unsigned LAP_W = 4,
    parameter int unsigned ERR_W = 8
);
    logic             step;
    logic [3:0]       state;
    logic             down;
    logic [3:0]       digit;
    logic [6:0]       seg;
    logic             synced;
    logic             illegal;
    logic             step_err;
    logic [ERR_W-1:0] err_count;
    logic [LAP_W-1:0] lap_count;

    modport master (
        output step, state, down,
        input  digit, seg, synced, illegal, step_err, err_count, lap_count
    );

    modport slave (
        input  step, state, down,
        output digit, seg, synced, illegal, step_err, err_count, lap_count
    );
endinterface

// File: rtl/seg7_encoder.sv
// Combinational digit to 7-segment {g,f,e,d,c,b,a} decode; blank for anything undefined.
module seg7_encoder
    import seq_state_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  digit_t digit,
    output seg_t   seg_c
);

    seg_t seg_hi;

    always_comb begin
        seg_hi = 7'h00;
        unique case (digit)
            DIG_2:   seg_hi = 7'h5B;
            DIG_3:   seg_hi = 7'h4F;
            DIG_5:   seg_hi = 7'h6D;
            DIG_6:   seg_hi = 7'h7D;
            default: seg_hi = 7'h00;
        endcase
    end

    assign seg_c = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seq_state_monitor.sv
// Samples the state bus on each step, decodes it for the display and checks ring-order legality.
module seq_state_monitor
    import seq_state_pkg::*;
#(
    parameter int unsigned LAP_W          = 4,
    parameter int unsigned ERR_W          = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    seq_state_monitor_if.slave bus
);

    localparam seg_t SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    code_t            code_c;
    logic             unused_state0;

    code_t            prev_q,     prev_d;
    logic             synced_q,   synced_d;
    logic             illegal_q,  illegal_d;
    logic             step_err_q, step_err_d;
    logic [ERR_W-1:0] err_q,      err_d;
    logic [LAP_W-1:0] lap_q,      lap_d;
    digit_t           digit_q,    digit_d;
    seg_t             seg_q,      seg_d;

    // Bus bit order is reversed relative to the code; bit 0 carries nothing.
    assign code_c        = {bus.state[1], bus.state[2], bus.state[3]};
    assign unused_state0 = bus.state[0];

    always_comb begin
        prev_d     = prev_q;
        synced_d   = synced_q;
        illegal_d  = illegal_q;
        step_err_d = 1'b0;
        err_d      = err_q;
        lap_d      = lap_q;
        digit_d    = digit_q;
        if (bus.step) begin
            if (!code_legal(code_c)) begin
                illegal_d = 1'b1;
                synced_d  = 1'b0;
                digit_d   = DIG_BLANK;
                if (synced_q) begin
                    step_err_d = 1'b1;
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                end
            end else begin
                prev_d    = code_c;
                synced_d  = 1'b1;
                illegal_d = 1'b0;
                digit_d   = code_digit(code_c);
                if (synced_q) begin
                    if (code_c == succ(prev_q, bus.down)) begin
                        // A lap is the wrap point between F and A, in either direction.
                        if (!bus.down && prev_q == CODE_F) lap_d = lap_q + LAP_W'(1);
                        if (bus.down && prev_q == CODE_A)  lap_d = lap_q - LAP_W'(1);
                    end else begin
                        step_err_d = 1'b1;
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                    end
                end
            end
        end
    end

    seg7_encoder #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_seg7 (
        .digit (digit_d),
        .seg_c (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= CODE_A;
            synced_q   <= 1'b0;
            illegal_q  <= 1'b0;
            step_err_q <= 1'b0;
            err_q      <= '0;
            lap_q      <= '0;
            digit_q    <= DIG_BLANK;
            seg_q      <= SEG_OFF;
        end else begin
            prev_q     <= prev_d;
            synced_q   <= synced_d;
            illegal_q  <= illegal_d;
            step_err_q <= step_err_d;
            err_q      <= err_d;
            lap_q      <= lap_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.digit     = digit_q;
    assign bus.seg       = seg_q;
    assign bus.synced    = synced_q;
    assign bus.illegal   = illegal_q;
    assign bus.step_err  = step_err_q;
    assign bus.err_count = err_q;
    assign bus.lap_count = lap_q;

endmodule

// File: tb/tb_seq_state_monitor.sv
// Randomized and directed checks of seq_state_monitor against a ring-position reference model.
module tb_seq_state_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_state_monitor_if #(.LAP_W(4), .ERR_W(8)) bus();

    seq_state_monitor #(
        .LAP_W          (4),
        .ERR_W          (8),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Ring order A..F as codes, with the digit each one shows.
    int ring_code[6] = '{5, 4, 3, 6, 7, 2};
    int ring_dig[6]  = '{3, 3, 3, 5, 6, 2};

    int m_synced, m_idx, m_lap, m_err, m_illegal, m_digit, m_step_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input int code);
        for (int i = 0; i < 6; i++) if (ring_code[i] == code) return i;
        return -1;
    endfunction

    // Glyphs by lit segments, then inverted for the common-anode board.
    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] lit;
        case (d)
            2:       lit = 7'b1011011;
            3:       lit = 7'b1001111;
            5:       lit = 7'b1101101;
            6:       lit = 7'b1111101;
            default: lit = 7'b0000000;
        endcase
        return ~lit;
    endfunction

    function automatic int code_at(input int i);
        return ring_code[i];
    endfunction

    task automatic model_reset();
        m_synced = 0; m_idx = 0; m_lap = 0; m_err = 0;
        m_illegal = 0; m_digit = 15; m_step_err = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".digit"},    32'(bus.digit),     32'(m_digit));
        chk({tag, ".seg"},      32'(bus.seg),       32'(exp_seg(m_digit)));
        chk({tag, ".synced"},   32'(bus.synced),    32'(m_synced));
        chk({tag, ".illegal"},  32'(bus.illegal),   32'(m_illegal));
        chk({tag, ".step_err"}, 32'(bus.step_err),  32'(m_step_err));
        chk({tag, ".err"},      32'(bus.err_count), 32'(m_err));
        chk({tag, ".lap"},      32'(bus.lap_count), 32'(m_lap & 15));
    endtask

    task automatic model_step(input int code, input bit dn);
        int i;
        int want;
        i = idx_of(code);
        m_step_err = 0;
        if (i < 0) begin
            if (m_synced != 0) begin
                m_step_err = 1;
                if (m_err < 255) m_err++;
            end
            m_illegal = 1; m_synced = 0; m_digit = 15;
        end else if (m_synced == 0) begin
            m_synced = 1; m_illegal = 0; m_idx = i; m_digit = ring_dig[i];
        end else begin
            want = dn ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
            if (i == want) begin
                if (!dn && m_idx == 5) m_lap++;
                if (dn && m_idx == 0) m_lap--;
            end else begin
                m_step_err = 1;
                if (m_err < 255) m_err++;
            end
            m_idx = i; m_digit = ring_dig[i]; m_illegal = 0;
        end
    endtask

    task automatic do_step(input string tag, input int code, input bit dn);
        logic [2:0] c;
        c = 3'(code);
        @(negedge clk);
        bus.step  = 1'b1;
        bus.state = {c[0], c[1], c[2], 1'($urandom_range(0, 1))};
        bus.down  = dn;
        model_step(code, dn);
        @(posedge clk);
        #1;
        bus.step = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        bus.state = 4'($urandom);
        bus.down  = 1'($urandom);
        @(posedge clk);
        #1;
        m_step_err = 0;
        check_all(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int r, nxt;
    bit dn;

    initial begin
        bus.step = 1'b0; bus.state = 4'h0; bus.down = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        chk("rst.seg_raw", 32'(bus.seg), 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;

        // First lock on A via the literal bus pattern.
        @(negedge clk);
        bus.step = 1'b1; bus.state = 4'b1010; bus.down = 1'b0;
        model_step(5, 1'b0);
        @(posedge clk); #1; bus.step = 1'b0;
        check_all("lock_a");
        chk("lock_a.digit3", 32'(bus.digit), 32'h3);

        for (int k = 1; k <= 6; k++) do_step("fwd", code_at(k % 6), 1'b0);
        chk("fwd.lap1", 32'(bus.lap_count), 32'h1);

        apply_reset();
        do_step("bk_lock", code_at(0), 1'b1);
        do_step("bk_f", code_at(5), 1'b1);
        chk("bk_f.lap", 32'(bus.lap_count), 32'hF);
        do_step("bk_e", code_at(4), 1'b1);
        do_step("bk_d", code_at(3), 1'b1);
        do_step("bk_c", code_at(2), 1'b1);
        do_step("bk_b", code_at(1), 1'b1);

        do_step("skip_d", code_at(3), 1'b0);
        chk("skip_d.pulse", 32'(bus.step_err), 32'h1);
        idle("skip_idle");
        do_step("skip_e", code_at(4), 1'b0);

        do_step("ill", 0, 1'b0);
        idle("ill_idle");
        do_step("ill_1", 1, 1'b1);
        do_step("relock_c", code_at(2), 1'b0);

        // Mostly-legal random walk with occasional faults and idle gaps.
        for (int k = 0; k < 300; k++) begin
            r  = $urandom_range(0, 99);
            dn = 1'($urandom);
            if (r < 70)      nxt = code_at(dn ? (m_idx + 5) % 6 : (m_idx + 1) % 6);
            else if (r < 85) nxt = code_at($urandom_range(0, 5));
            else             nxt = $urandom_range(0, 1);
            do_step("rnd", nxt, dn);
            if ($urandom_range(0, 3) == 0) idle("rnd_idle");
        end

        do_step("sat_lock", code_at(0), 1'b0);
        for (int k = 0; k < 260; k++) do_step("sat", code_at(0), 1'($urandom));
        chk("sat.err255", 32'(bus.err_count), 32'd255);
        chk("sat.pulse", 32'(bus.step_err), 32'h1);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_step("post_rst", code_at(1), 1'b0);
        do_step("post_rst_c", code_at(2), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_state_monitor.md
Name: seq_state_monitor

Overview:
- Sequential reader and decoder for the 6-state display-sequence state bus (A..F) produced by the next-state logic and its state register.
- On each step strobe it samples the 4-bit state bus and the direction.
- It decodes the state to the displayed digit and 7-segment pattern, checks that each step is the legal successor for the sampled direction, and tracks completed laps and step errors.
- Sits between the state register and the display/LED board.

Parameters:
LAP_W, 4, width of the lap counter (wraps modulo 2^LAP_W)
ERR_W, 8, width of the step-error counter (saturating)
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (common-anode), 0 = active-high

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- step  input  1  one-cycle strobe: the state bus holds a new value this cycle.
- state  input  4  state bus; bit 0 unused/ignored; code = {state[1],state[2],state[3]}.
- down  input  1  direction of the step just taken: 0 = forward, 1 = backward.
- digit  output  4  decoded digit value (0xF = blank).
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- synced  output  1  a legal reference state is held.
- illegal  output  1  last sample was an illegal code (sticky until next legal sample).
- step_err  output  1  one-cycle pulse: illegal transition detected.
- err_count  output  ERR_W  saturating count of step errors.
- lap_count  output  LAP_W  signed-wrap lap counter.

Behaviour:
- State codes (code = {state[1],state[2],state[3]}), with digits:
  - A=101 → 3
  - B=100 → 3
  - C=011 → 3
  - D=110 → 5
  - E=111 → 6
  - F=010 → 2
  - 000 and 001 are illegal.
- Forward successor (down=0): A→B→C→D→E→F→A. Backward successor (down=1): the reverse.
- Reset (rst_n=0, asynchronous): digit=0xF, seg=all-off, synced=0, illegal=0, step_err=0, err_count=0, lap_count=0, stored previous code = none.
- Cycles with step=0: all registers hold; step_err is 0.
- Latency: all outputs are registered and update on the rising edge that samples step=1, visible the following cycle.
- Step with illegal code:
  - illegal=1, synced=0, digit=0xF, seg=off.
  - step_err=1 only if synced was 1; err_count increments in that case.
  - lap_count is unchanged.
- Step with legal code while synced=0 (first lock):
  - Store the code; synced=1, illegal=0.
  - digit/seg decoded from the code.
  - No transition check; no step_err.
- Step with legal code while synced=1:
  - Compare against the successor of the stored code for the sampled down.
  - Match: update digit/seg and store the code.
    - Forward F→A: lap_count+1, wrapping at 2^LAP_W-1 → 0.
    - Backward A→F: lap_count-1, wrapping 0 → 2^LAP_W-1.
  - Mismatch, including a repeat of the same code: step_err=1 and err_count+1.
    - Still store the new code and display it; synced stays 1 (resynchronise on the new code).
    - lap_count unchanged.
- err_count saturates at 2^ERR_W-1. step_err still pulses after saturation.
- Digit/segment encoding uses standard 7-segment glyphs for 2, 3, 5, 6; blank = all segments off. Outputs are inverted when SEG_ACTIVE_LOW=1.
- down is sampled only together with step; mid-stream direction reversal is legal if each step matches the successor for its own down value.
- Reset asserted mid-stream clears everything. The first post-reset step is a first-lock, never an error.

Decomposition:
- Package seq_state_pkg:
  - 3-bit code constants CODE_A..CODE_F.
  - Digit constants DIG_3, DIG_5, DIG_6, DIG_2, DIG_BLANK.
  - Function succ(code, down) returning the expected next code.
  - Function code_legal(code).
- Sub-module seg7_encoder: combinational digit→7-segment decode with a SEG_ACTIVE_LOW parameter, instantiated once.

Test Plan:
1. Reset → seg=7'h7F (active-low blank), digit=0xF, synced=0. Then step with code A (state=4'b1010) → digit=3, synced=1, step_err=0.
2. From A, six forward steps B,C,D,E,F,A with down=0 → digits 3,3,5,6,2,3; lap_count=1; err_count=0.
3. From A with down=1, step to F, then E → digits 2,6; lap_count decrements by 1 (0→0xF from reset); no errors.
4. Synced on B, step with code D and down=0 → step_err pulses 1 for exactly one cycle; err_count=1; digit=5; next legal step E is accepted with no error.
5. Step with code 000 while synced → illegal=1, synced=0, digit=0xF, err_count+1. Next step with code C → first lock, no error, digit=3.
6. Force 260 consecutive mismatched steps with ERR_W=8 → err_count holds at 255; step_err still pulses on each. Then assert rst_n=0 mid-sequence → all outputs return to reset values immediately, without waiting for a clock edge.
